// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath.
// Each instruction passes through FETCH/DECODE/EXEC/(MEM)/(WB). The controller
// waits on the imem/dmem ready handshakes and drives the datapath enables and
// mux selects. It counts retired instructions and stops permanently on an
// illegal opcode or a memory timeout. Outputs decode the current state and the
// latched opcode. The only inputs they also use are imem_ready (fetch
// completion), dmem_ready (store retire) and zero (branch taken).
module multicycle_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic             reg_write_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic [1:0]       alu_op_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instr_count_o,
  output logic             halted_o,
  output logic [1:0]       err_code_o
);

  // The wait counter only has to reach TIMEOUT-1.
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM    = 2'b10;
  localparam logic [1:0] ERR_DMEM    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [WC_W-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic [1:0]         err_q, err_d;

  logic               imem_req_s;
  logic               ir_write_s;
  logic               pc_write_s;
  logic               pc_src_s;
  logic               dmem_read_s;
  logic               dmem_write_s;
  logic               reg_write_s;
  logic               alu_src_s;
  logic               mem_to_reg_s;
  logic [1:0]         alu_op_s;
  logic               retire_s;
  logic               wait_expired_s;

  // Only the four supported opcodes are legal; anything else, including
  // unknown bits, falls to the default branch and is illegal.
  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The last allowed wait cycle is reached when the counter hits TIMEOUT-1.
  assign wait_expired_s = (wait_q == WC_W'(TIMEOUT - 1));

  // State and bookkeeping registers; reset returns to IDLE and drops any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 7'd0;
      wait_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and per-state datapath control decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = wait_q;
    halted_d     = halted_q;
    err_d        = err_q;
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    dmem_read_s  = 1'b0;
    dmem_write_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_op_s     = ALU_ADD;
    retire_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready_i) begin
          // PC+4 is written together with the IR; IR write also saves the old PC.
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          pc_src_s   = 1'b0;
          wait_d     = '0;
          state_d    = S_DECODE;
        end else if (wait_expired_s) begin
          wait_d   = '0;
          halted_d = 1'b1;
          err_d    = ERR_IMEM;
          state_d  = S_HALT;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end

      S_DECODE: begin
        op_d = opcode_i;
        if (is_legal(opcode_i)) begin
          state_d = S_EXEC;
        end else begin
          halted_d = 1'b1;
          err_d    = ERR_ILLEGAL;
          state_d  = S_HALT;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            alu_op_s  = ALU_FN;
            alu_src_s = 1'b0;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op_s  = ALU_ADD;
            alu_src_s = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            // Branch retires here: PC takes old_pc+imm only when the compare is equal.
            alu_op_s   = ALU_SUB;
            alu_src_s  = 1'b0;
            pc_src_s   = 1'b1;
            pc_write_s = zero_i;
            retire_s   = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            // Unreachable because DECODE filters opcodes; fail safe anyway.
            halted_d = 1'b1;
            err_d    = ERR_ILLEGAL;
            state_d  = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        alu_src_s = 1'b1;
        if (op_q == OP_LOAD) begin
          dmem_read_s = 1'b1;
        end else begin
          dmem_write_s = 1'b1;
        end
        if (dmem_ready_i) begin
          wait_d = '0;
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (wait_expired_s) begin
          wait_d   = '0;
          halted_d = 1'b1;
          err_d    = ERR_DMEM;
          state_d  = S_HALT;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end

      S_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (op_q == OP_LOAD);
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        halted_d = 1'b1;
        err_d    = ERR_ILLEGAL;
        state_d  = S_HALT;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign imem_req_o    = imem_req_s;
  assign ir_write_o    = ir_write_s;
  assign pc_write_o    = pc_write_s;
  assign pc_src_o      = pc_src_s;
  assign dmem_read_o   = dmem_read_s;
  assign dmem_write_o  = dmem_write_s;
  assign reg_write_o   = reg_write_s;
  assign alu_src_o     = alu_src_s;
  assign mem_to_reg_o  = mem_to_reg_s;
  assign alu_op_o      = alu_op_s;
  assign retire_o      = retire_s;
  assign instr_count_o = cnt_q;
  assign halted_o      = halted_q;
  assign err_code_o    = err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (CNT_W=4, TIMEOUT=4).
// A per-cycle vector table covers R/load/store/branch/illegal flows. Hand
// sequences cover the timeouts, counter wrap and asynchronous reset mid-MEM.
module tb_multicycle_ctrl_fsm;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  // Packed expected-output bit positions:
  // {imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write, reg_write,
  //  alu_src, mem_to_reg, alu_op[1:0], retire, halted, err_code[1:0]}
  localparam logic [14:0] IREQ = 15'h4000;
  localparam logic [14:0] IRW  = 15'h2000;
  localparam logic [14:0] PCW  = 15'h1000;
  localparam logic [14:0] PCS  = 15'h0800;
  localparam logic [14:0] DRD  = 15'h0400;
  localparam logic [14:0] DWR  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] ASRC = 15'h0080;
  localparam logic [14:0] M2R  = 15'h0040;
  localparam logic [14:0] AFN  = 15'h0020;
  localparam logic [14:0] ASUB = 15'h0010;
  localparam logic [14:0] RET  = 15'h0008;
  localparam logic [14:0] HLT  = 15'h0004;
  localparam logic [14:0] E01  = 15'h0001;
  localparam logic [14:0] E10  = 15'h0002;
  localparam logic [14:0] E11  = 15'h0003;
  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] FET  = IREQ | IRW | PCW;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPX = 7'b0010111;

  typedef struct packed {
    logic [6:0]  op;
    logic        zero;
    logic        iready;
    logic        dready;
    logic [14:0] exp;
    logic [3:0]  cnt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req, ir_write, pc_write, pc_src;
  logic             dmem_read, dmem_write, reg_write, alu_src, mem_to_reg;
  logic [1:0]       alu_op;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic [1:0]       err_code;

  int checks;
  int failures;
  vec_t vq[$];

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode_i      (opcode),
    .zero_i        (zero),
    .imem_ready_i  (imem_ready),
    .dmem_ready_i  (dmem_ready),
    .imem_req_o    (imem_req),
    .ir_write_o    (ir_write),
    .pc_write_o    (pc_write),
    .pc_src_o      (pc_src),
    .dmem_read_o   (dmem_read),
    .dmem_write_o  (dmem_write),
    .reg_write_o   (reg_write),
    .alu_src_o     (alu_src),
    .mem_to_reg_o  (mem_to_reg),
    .alu_op_o      (alu_op),
    .retire_o      (retire),
    .instr_count_o (instr_count),
    .halted_o      (halted),
    .err_code_o    (err_code)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] outs();
    return {imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write,
            reg_write, alu_src, mem_to_reg, alu_op, retire, halted, err_code};
  endfunction

  task automatic check(input string name, input logic [14:0] exp, input logic [3:0] cnt);
    checks++;
    if (outs() !== exp || instr_count !== cnt) begin
      failures++;
      $display("FAIL %s: outputs=%h count=%0d, expected outputs=%h count=%0d",
               name, outs(), instr_count, exp, cnt);
    end
  endtask

  // Called at a falling edge: drive inputs, check the current cycle, move to next falling edge.
  task automatic step(input string name, input logic [6:0] op, input logic z,
                      input logic ir, input logic dr,
                      input logic [14:0] exp, input logic [3:0] cnt);
    opcode     = op;
    zero       = z;
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    check(name, exp, cnt);
    @(negedge clk);
  endtask

  // Hold reset for two cycles and release on a falling edge (IDLE cycle follows).
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [6:0] op, input logic z, input logic ir,
                     input logic dr, input logic [14:0] exp, input logic [3:0] cnt);
    vq.push_back('{op, z, ir, dr, exp, cnt});
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    opcode     = 7'd0;
    zero       = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    // Reset state: all outputs 0 while rst_n is low.
    #2;
    check("reset_state", NONE, 4'd0);

    // One row per cycle: op, zero, imem_ready, dmem_ready, expected outputs, count.
    add(OPR, 1'b0, 1'b1, 1'b1, NONE,              4'd0); // IDLE, readies ignored
    add(OPR, 1'b0, 1'b1, 1'b0, FET,               4'd0); // R: FETCH
    add(OPR, 1'b0, 1'b1, 1'b0, NONE,              4'd0); // DECODE
    add(OPR, 1'b0, 1'b1, 1'b0, AFN,               4'd0); // EXEC
    add(OPR, 1'b0, 1'b1, 1'b0, RW | RET,          4'd0); // WB
    add(OPL, 1'b0, 1'b1, 1'b0, FET,               4'd1); // load FETCH
    add(OPL, 1'b0, 1'b1, 1'b0, NONE,              4'd1); // DECODE
    add(OPL, 1'b0, 1'b1, 1'b0, ASRC,              4'd1); // EXEC
    add(OPL, 1'b0, 1'b0, 1'b0, DRD | ASRC,        4'd1); // MEM wait 1
    add(OPL, 1'b0, 1'b0, 1'b0, DRD | ASRC,        4'd1); // MEM wait 2
    add(OPL, 1'b0, 1'b0, 1'b0, DRD | ASRC,        4'd1); // MEM wait 3
    add(OPL, 1'b0, 1'b0, 1'b1, DRD | ASRC,        4'd1); // MEM ready
    add(OPL, 1'b0, 1'b0, 1'b0, RW | M2R | RET,    4'd1); // WB, read dropped
    add(OPS, 1'b0, 1'b0, 1'b0, IREQ,              4'd2); // store FETCH wait
    add(OPS, 1'b0, 1'b1, 1'b0, FET,               4'd2); // FETCH ready
    add(OPS, 1'b0, 1'b0, 1'b0, NONE,              4'd2); // DECODE
    add(OPS, 1'b0, 1'b0, 1'b0, ASRC,              4'd2); // EXEC
    add(OPS, 1'b0, 1'b0, 1'b0, DWR | ASRC,        4'd2); // MEM wait 1
    add(OPS, 1'b0, 1'b0, 1'b0, DWR | ASRC,        4'd2); // MEM wait 2
    add(OPS, 1'b0, 1'b0, 1'b0, DWR | ASRC,        4'd2); // MEM wait 3
    add(OPS, 1'b0, 1'b0, 1'b1, DWR | ASRC | RET,  4'd2); // MEM ready, retire
    add(OPB, 1'b1, 1'b1, 1'b0, FET,               4'd3); // branch taken FETCH
    add(OPB, 1'b1, 1'b1, 1'b0, NONE,              4'd3); // DECODE
    add(OPB, 1'b1, 1'b1, 1'b0, ASUB | PCS | PCW | RET, 4'd3); // EXEC zero=1
    add(OPB, 1'b0, 1'b1, 1'b0, FET,               4'd4); // branch not taken
    add(OPB, 1'b0, 1'b1, 1'b0, NONE,              4'd4); // DECODE
    add(OPB, 1'b0, 1'b1, 1'b0, ASUB | PCS | RET,  4'd4); // EXEC zero=0
    add(OPX, 1'b0, 1'b1, 1'b1, FET,               4'd5); // FETCH, dmem_ready ignored
    add(OPX, 1'b0, 1'b1, 1'b1, NONE,              4'd5); // DECODE illegal
    add(OPX, 1'b0, 1'b1, 1'b1, HLT | E01,         4'd5); // HALT
    add(OPR, 1'b0, 1'b1, 1'b1, HLT | E01,         4'd5); // stays halted

    @(negedge clk);
    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].op, vq[i].zero, vq[i].iready,
           vq[i].dready, vq[i].exp, vq[i].cnt);
    end

    // imem timeout: TIMEOUT fetch cycles without ready, then halt with err 10.
    do_reset();
    step("imem_to_idle", OPR, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step($sformatf("imem_to_fetch%0d", i), OPR, 1'b0, 1'b0, 1'b0, IREQ, 4'd0);
    end
    step("imem_to_halt",   OPR, 1'b0, 1'b0, 1'b0, HLT | E10, 4'd0);
    step("imem_to_sticky", OPR, 1'b0, 1'b1, 1'b1, HLT | E10, 4'd0);

    // dmem timeout on a load: TIMEOUT MEM cycles, then halt with err 11.
    do_reset();
    step("dmem_to_idle",   OPL, 1'b0, 1'b1, 1'b0, NONE, 4'd0);
    step("dmem_to_fetch",  OPL, 1'b0, 1'b1, 1'b0, FET,  4'd0);
    step("dmem_to_decode", OPL, 1'b0, 1'b1, 1'b0, NONE, 4'd0);
    step("dmem_to_exec",   OPL, 1'b0, 1'b1, 1'b0, ASRC, 4'd0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step($sformatf("dmem_to_mem%0d", i), OPL, 1'b0, 1'b1, 1'b0, DRD | ASRC, 4'd0);
    end
    step("dmem_to_halt",   OPL, 1'b0, 1'b1, 1'b0, HLT | E11, 4'd0);
    step("dmem_to_sticky", OPL, 1'b0, 1'b1, 1'b1, HLT | E11, 4'd0);

    // 16 back-to-back branches wrap the 4-bit counter to 0.
    do_reset();
    step("wrap_idle", OPB, 1'b0, 1'b1, 1'b0, NONE, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wrap_f%0d", i), OPB, 1'b0, 1'b1, 1'b0, FET,  4'(i));
      step($sformatf("wrap_d%0d", i), OPB, 1'b0, 1'b1, 1'b0, NONE, 4'(i));
      step($sformatf("wrap_e%0d", i), OPB, 1'b0, 1'b1, 1'b0, ASUB | PCS | RET, 4'(i));
    end
    // One more branch after the wrap, so the count is nonzero before the reset.
    step("wrap_f16", OPB, 1'b1, 1'b1, 1'b0, FET,  4'd0);
    step("wrap_d16", OPB, 1'b1, 1'b1, 1'b0, NONE, 4'd0);
    step("wrap_e16", OPB, 1'b1, 1'b1, 1'b0, ASUB | PCS | PCW | RET, 4'd0);

    // Reset asserted mid-MEM: outputs drop at once, restart from IDLE.
    step("rst_fetch",  OPL, 1'b0, 1'b1, 1'b0, FET,        4'd1);
    step("rst_decode", OPL, 1'b0, 1'b1, 1'b0, NONE,       4'd1);
    step("rst_exec",   OPL, 1'b0, 1'b1, 1'b0, ASRC,       4'd1);
    step("rst_mem",    OPL, 1'b0, 1'b1, 1'b0, DRD | ASRC, 4'd1);
    dmem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", NONE, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_idle",    OPL, 1'b0, 1'b1, 1'b1, NONE, 4'd0);
    step("rst_refetch", OPL, 1'b0, 1'b1, 1'b1, FET,  4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
